// File: rtl/pipeline_fetch_queue.sv
// pipeline_fetch_queue
// Producing end of the fetch->decode interface. Issues in-order word reads to
// instruction memory, buffers the returned words in a small prefetch queue and
// presents one instruction per cycle to decode. Handles the decode redirect
// (including the MIPS branch delay slot) and tags every instruction with a
// 1-bit fetch epoch so stale responses and hazard logic can tell streams apart.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   stallOnDecode         decode cannot accept; output register holds
//   jumpEnabled/jumpValue redirect request and target PC from decode
//   imemReq*              read request channel (valid/ready, word address)
//   imemResp*             read data, returned strictly in request order
//   fetch*                presented instruction: PC, epoch, word, bubble flag
module pipeline_fetch_queue #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_3000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stallOnDecode,
    input  logic        jumpEnabled,
    input  logic [31:0] jumpValue,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddress,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic [31:0] fetchProgramCounter,
    output logic        fetchChangedTimes,
    output logic [31:0] fetchInstruction,
    output logic        fetchBubbled
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(QUEUE_DEPTH);

    typedef enum logic [0:0] {
        NORMAL     = 1'b0,
        DELAY_SLOT = 1'b1
    } fetchState_t;

    fetchState_t      state_r;
    logic [31:0]      fetchPc_r;
    logic [31:0]      pendingTarget_r;
    logic             epoch_r;
    logic [CNT_W-1:0] inFlight_r;
    logic [CNT_W-1:0] queueCount_r;
    logic [PTR_W-1:0] qHead_r;
    logic [PTR_W-1:0] qTail_r;
    logic [PTR_W-1:0] tagWr_r;
    logic [PTR_W-1:0] tagRd_r;

    // Storage carries no reset: validity is tracked by the counters/pointers.
    logic [31:0] qPc_r      [QUEUE_DEPTH];
    logic        qEpoch_r   [QUEUE_DEPTH];
    logic [31:0] qData_r    [QUEUE_DEPTH];
    logic        tagEpoch_r [QUEUE_DEPTH];
    logic [31:0] tagPc_r    [QUEUE_DEPTH];

    logic [31:0] outPc_r;
    logic        outChanged_r;
    logic [31:0] outInstr_r;
    logic        outBubbled_r;

    logic        reqValid_s;
    logic        issueFire_s;
    logic        respFire_s;
    logic        respMatch_s;
    logic        queueNonEmpty_s;
    logic        loadHead_s;
    logic        loadBubble_s;
    logic        redirect_s;
    logic        enterDelay_s;
    logic [31:0] redirectTarget_s;
    logic        pushQueue_s;

    // Credit check: requests in flight plus buffered words never exceed the queue depth.
    always_comb begin
        reqValid_s  = !reset &&
                      (({1'b0, inFlight_r} + {1'b0, queueCount_r}) < CREDIT_MAX);
        issueFire_s = reqValid_s && imemReqReady;
        // Responses with nothing outstanding belong to a pre-reset stream.
        respFire_s  = imemRespValid && (inFlight_r != '0);
        respMatch_s = respFire_s && (tagEpoch_r[tagRd_r] == epoch_r);
        queueNonEmpty_s = (queueCount_r != '0);
    end

    // Output/redirect decision for this cycle.
    always_comb begin
        loadHead_s       = 1'b0;
        loadBubble_s     = 1'b0;
        redirect_s       = 1'b0;
        enterDelay_s     = 1'b0;
        redirectTarget_s = pendingTarget_r;
        case (state_r)
            NORMAL: begin
                if (stallOnDecode) begin
                    loadHead_s = 1'b0;
                end else if (jumpEnabled) begin
                    if (queueNonEmpty_s) begin
                        // Head is the delay slot; the rest of the queue is wrong-path.
                        loadHead_s       = 1'b1;
                        redirect_s       = 1'b1;
                        redirectTarget_s = jumpValue;
                    end else begin
                        // Delay slot not fetched yet: remember the target and wait for it.
                        loadBubble_s = 1'b1;
                        enterDelay_s = 1'b1;
                    end
                end else if (queueNonEmpty_s) begin
                    loadHead_s = 1'b1;
                end else begin
                    loadBubble_s = 1'b1;
                end
            end
            DELAY_SLOT: begin
                if (!stallOnDecode && queueNonEmpty_s) begin
                    loadHead_s       = 1'b1;
                    redirect_s       = 1'b1;
                    redirectTarget_s = pendingTarget_r;
                end else if (!stallOnDecode) begin
                    loadBubble_s = 1'b1;
                end else begin
                    loadHead_s = 1'b0;
                end
            end
            default: begin
                loadBubble_s = 1'b1;
            end
        endcase
        // A word arriving during a redirect belongs to the abandoned path.
        pushQueue_s = respMatch_s && !redirect_s;
    end

    // Control state, counters and pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= NORMAL;
            fetchPc_r       <= RESET_PC;
            pendingTarget_r <= RESET_PC;
            epoch_r         <= 1'b0;
            inFlight_r      <= '0;
            queueCount_r    <= '0;
            qHead_r         <= '0;
            qTail_r         <= '0;
            tagWr_r         <= '0;
            tagRd_r         <= '0;
        end else begin
            if (redirect_s) begin
                fetchPc_r <= redirectTarget_s;
                epoch_r   <= ~epoch_r;
                state_r   <= NORMAL;
            end else if (issueFire_s) begin
                fetchPc_r <= fetchPc_r + 32'd4;
            end
            if (enterDelay_s) begin
                state_r         <= DELAY_SLOT;
                pendingTarget_r <= jumpValue;
            end
            case ({issueFire_s, respFire_s})
                2'b10:   inFlight_r <= inFlight_r + CNT_ONE;
                2'b01:   inFlight_r <= inFlight_r - CNT_ONE;
                default: inFlight_r <= inFlight_r;
            endcase
            if (issueFire_s) tagWr_r <= tagWr_r + PTR_ONE;
            if (respFire_s)  tagRd_r <= tagRd_r + PTR_ONE;
            if (redirect_s) begin
                queueCount_r <= '0;
                qHead_r      <= '0;
                qTail_r      <= '0;
            end else begin
                if (pushQueue_s) qTail_r <= qTail_r + PTR_ONE;
                if (loadHead_s)  qHead_r <= qHead_r + PTR_ONE;
                case ({pushQueue_s, loadHead_s})
                    2'b10:   queueCount_r <= queueCount_r + CNT_ONE;
                    2'b01:   queueCount_r <= queueCount_r - CNT_ONE;
                    default: queueCount_r <= queueCount_r;
                endcase
            end
        end
    end

    // Request tag/PC FIFO and prefetch queue storage.
    always_ff @(posedge clock) begin
        if (issueFire_s) begin
            tagEpoch_r[tagWr_r] <= epoch_r;
            tagPc_r[tagWr_r]    <= fetchPc_r;
        end
        if (pushQueue_s) begin
            qPc_r[qTail_r]    <= tagPc_r[tagRd_r];
            qEpoch_r[qTail_r] <= tagEpoch_r[tagRd_r];
            qData_r[qTail_r]  <= imemRespData;
        end
    end

    // Output register towards decode; a bubble keeps the previous PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            outPc_r      <= RESET_PC;
            outChanged_r <= 1'b0;
            outInstr_r   <= 32'h0;
            outBubbled_r <= 1'b1;
        end else if (loadHead_s) begin
            outPc_r      <= qPc_r[qHead_r];
            outChanged_r <= qEpoch_r[qHead_r];
            outInstr_r   <= qData_r[qHead_r];
            outBubbled_r <= 1'b0;
        end else if (loadBubble_s) begin
            outChanged_r <= epoch_r;
            outInstr_r   <= 32'h0;
            outBubbled_r <= 1'b1;
        end else begin
            outBubbled_r <= outBubbled_r;
        end
    end

    assign imemReqValid        = reqValid_s;
    assign imemReqAddress      = fetchPc_r;
    assign fetchProgramCounter = outPc_r;
    assign fetchChangedTimes   = outChanged_r;
    assign fetchInstruction    = outInstr_r;
    assign fetchBubbled        = outBubbled_r;

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Directed bench for pipeline_fetch_queue with a behavioural in-order
// instruction memory (fixed, random or single-outstanding latency).
module tb_pipeline_fetch_queue;

    logic        clock;
    logic        reset;
    logic        stallOnDecode;
    logic        jumpEnabled;
    logic [31:0] jumpValue;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddress;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic [31:0] fetchProgramCounter;
    logic        fetchChangedTimes;
    logic [31:0] fetchInstruction;
    logic        fetchBubbled;

    int checks = 0;
    int errors = 0;
    int lastWait = 0;

    // memory model configuration, written by the stimulus
    int memLatency        = 1;
    bit memRandomLat      = 1'b0;
    bit memRandomReady    = 1'b0;
    bit memOneOutstanding = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;
    memReq_t memQ[$];
    int memCycle = 0;
    bit staleNext = 1'b0;

    pipeline_fetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
        .clock               (clock),
        .reset               (reset),
        .stallOnDecode       (stallOnDecode),
        .jumpEnabled         (jumpEnabled),
        .jumpValue           (jumpValue),
        .imemReqValid        (imemReqValid),
        .imemReqReady        (imemReqReady),
        .imemReqAddress      (imemReqAddress),
        .imemRespValid       (imemRespValid),
        .imemRespData        (imemRespData),
        .fetchProgramCounter (fetchProgramCounter),
        .fetchChangedTimes   (fetchChangedTimes),
        .fetchInstruction    (fetchInstruction),
        .fetchBubbled        (fetchBubbled)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] instrFor(input logic [31:0] pc);
        return pc ^ 32'h1234_0000;
    endfunction

    // Memory: decisions made just after each falling edge for the next rising edge.
    initial begin
        int lat;
        imemReqReady  = 1'b0;
        imemRespValid = 1'b0;
        imemRespData  = 32'h0;
        forever begin
            @(negedge clock);
            #1;
            memCycle++;
            imemRespValid = 1'b0;
            imemRespData  = 32'h0;
            if (reset) begin
                memQ.delete();
                imemRespValid = 1'b1;
                imemRespData  = 32'hDEAD_BEEF;
                imemReqReady  = 1'b1;
                staleNext     = 1'b1;
            end else begin
                if (staleNext) begin
                    imemRespValid = 1'b1;
                    imemRespData  = 32'hBAD0_0BAD;
                    staleNext     = 1'b0;
                end else if (memQ.size() > 0 && memQ[0].due <= memCycle) begin
                    imemRespValid = 1'b1;
                    imemRespData  = instrFor(memQ[0].addr);
                    void'(memQ.pop_front());
                end
                if (memOneOutstanding)   imemReqReady = (memQ.size() == 0);
                else if (memRandomReady) imemReqReady = ($urandom_range(0, 1) == 1);
                else                     imemReqReady = 1'b1;
                if (imemReqValid && imemReqReady) begin
                    lat = memRandomLat ? int'($urandom_range(1, 6)) : memLatency;
                    memQ.push_back('{imemReqAddress, memCycle + lat});
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the currently presented instruction.
    task automatic checkCur(input string tag, input logic [31:0] pc, input logic ep);
        check32({tag, "_bubbled"}, {31'b0, fetchBubbled}, 32'h0);
        check32({tag, "_pc"}, fetchProgramCounter, pc);
        check32({tag, "_instr"}, fetchInstruction, instrFor(pc));
        check32({tag, "_epoch"}, {31'b0, fetchChangedTimes}, {31'b0, ep});
    endtask

    // Advances to the next non-bubble output (bounded) and checks it.
    task automatic waitOut(input string tag, input logic [31:0] pc, input logic ep);
        int n = 0;
        do begin
            tick();
            n++;
        end while (fetchBubbled && n < 40);
        lastWait = n;
        checkCur(tag, pc, ep);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        reset         = 1'b1;
        stallOnDecode = 1'b0;
        jumpEnabled   = 1'b0;
        jumpValue     = 32'h0;

        // reset state
        tick();
        tick();
        check32("rst_reqvalid", {31'b0, imemReqValid}, 32'h0);
        check32("rst_bubbled", {31'b0, fetchBubbled}, 32'h1);
        check32("rst_pc", fetchProgramCounter, 32'h0000_3000);
        check32("rst_instr", fetchInstruction, 32'h0);
        check32("rst_epoch", {31'b0, fetchChangedTimes}, 32'h0);
        reset = 1'b0;

        // streaming with 1-cycle memory
        waitOut("s1_3000", 32'h0000_3000, 1'b0);
        check32("s1_first_latency", {31'b0, lastWait <= 3}, 32'h1);
        waitOut("s1_3004", 32'h0000_3004, 1'b0);
        check32("s1_consecutive", lastWait, 32'd1);
        waitOut("s1_3008", 32'h0000_3008, 1'b0);
        check32("s1_consecutive2", lastWait, 32'd1);

        // stall from output 0x3004
        doReset();
        waitOut("s2_3000", 32'h0000_3000, 1'b0);
        waitOut("s2_3004", 32'h0000_3004, 1'b0);
        stallOnDecode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check32("s2_hold_pc", fetchProgramCounter, 32'h0000_3004);
            check32("s2_hold_bub", {31'b0, fetchBubbled}, 32'h0);
        end
        check32("s2_reqvalid_full", {31'b0, imemReqValid}, 32'h0);
        stallOnDecode = 1'b0;
        pc = 32'h0000_3008;
        for (int i = 0; i < 6; i++) begin
            waitOut("s2_release", pc, 1'b0);
            pc = pc + 32'd4;
        end

        // jump at 0x3008 with non-empty queue
        doReset();
        waitOut("s3_3000", 32'h0000_3000, 1'b0);
        waitOut("s3_3004", 32'h0000_3004, 1'b0);
        waitOut("s3_3008", 32'h0000_3008, 1'b0);
        jumpEnabled = 1'b1;
        jumpValue   = 32'h0000_3100;
        tick();
        jumpEnabled = 1'b0;
        checkCur("s3_delayslot", 32'h0000_300C, 1'b0);
        waitOut("s3_target", 32'h0000_3100, 1'b1);
        waitOut("s3_target4", 32'h0000_3104, 1'b1);

        // same jump, 5-cycle memory, one request outstanding -> empty queue at jump
        memLatency        = 5;
        memOneOutstanding = 1'b1;
        doReset();
        waitOut("s4_3000", 32'h0000_3000, 1'b0);
        waitOut("s4_3004", 32'h0000_3004, 1'b0);
        waitOut("s4_3008", 32'h0000_3008, 1'b0);
        jumpEnabled = 1'b1;
        jumpValue   = 32'h0000_3100;
        tick();
        jumpEnabled = 1'b0;
        check32("s4_bubble", {31'b0, fetchBubbled}, 32'h1);
        check32("s4_bubble_pc", fetchProgramCounter, 32'h0000_3008);
        check32("s4_bubble_instr", fetchInstruction, 32'h0);
        waitOut("s4_delayslot", 32'h0000_300C, 1'b0);
        waitOut("s4_target", 32'h0000_3100, 1'b1);
        waitOut("s4_target4", 32'h0000_3104, 1'b1);
        memOneOutstanding = 1'b0;

        // random ready and latency against a PC+4 golden stream
        memRandomLat   = 1'b1;
        memRandomReady = 1'b1;
        doReset();
        pc = 32'h0000_3000;
        for (int i = 0; i < 40; i++) begin
            waitOut("s5_random", pc, 1'b0);
            pc = pc + 32'd4;
        end
        memRandomLat   = 1'b0;
        memRandomReady = 1'b0;

        // reset in the middle of a stream with requests in flight
        memLatency = 3;
        waitOut("s6_pre", pc, 1'b0);
        reset = 1'b1;
        tick();
        check32("s6_rst_bubbled", {31'b0, fetchBubbled}, 32'h1);
        check32("s6_rst_pc", fetchProgramCounter, 32'h0000_3000);
        check32("s6_rst_instr", fetchInstruction, 32'h0);
        check32("s6_rst_reqvalid", {31'b0, imemReqValid}, 32'h0);
        reset = 1'b0;
        waitOut("s6_3000", 32'h0000_3000, 1'b0);
        waitOut("s6_3004", 32'h0000_3004, 1'b0);
        waitOut("s6_3008", 32'h0000_3008, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
